mux_rr_arbiter: RTL

//  Round-robin arbiter sharing the 4:1 Multiplexor between four requesters.

---
 rtl/mux_rr_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that shares the 4:1 multiplexor between four requesters.
// Drives the mux select and a one-hot grant. An owner may keep the grant while
// it requests, but for at most MAX_HOLD cycles while another requester waits.
// All outputs are registered.
module mux_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [3:0]       i_req,
    output logic [3:0]       o_gnt,
    output logic [1:0]       o_sel,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_hold_cnt
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       last_q, last_d;

    logic [3:0]       others;

    // First set bit of req, scanning upward from last+1 and wrapping 3->0.
    // Bit 'last' itself is visited last, so masking it out excludes the owner.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] pick;
        logic       hit;
        pick = last;
        hit  = 1'b0;
        for (int unsigned i = 1; i <= 4; i++) begin
            logic [1:0] cand;
            cand = last + 2'(i);
            if (!hit && req[cand]) begin
                pick = cand;
                hit  = 1'b1;
            end
        end
        return pick;
    endfunction

    // State, grant and select registers; async reset leaves index 0 on top.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            last_q  <= 2'd3;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    // Next-state logic: arbitration on entry, release, forced rotation, hold count.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        // In GRANT, sel_q is the owner index.
        others  = i_req & ~(4'(1) << sel_q);

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (|i_req) begin
                    state_d = GRANT;
                    sel_d   = rr_pick(i_req, last_q);
                    gnt_d   = 4'(1) << rr_pick(i_req, last_q);
                    busy_d  = 1'b1;
                end
            end
            GRANT: begin
                if (!i_req[sel_q]) begin
                    // Release: hand over on the same edge so there is no idle bubble.
                    last_d = sel_q;
                    cnt_d  = '0;
                    if (|i_req) begin
                        sel_d = rr_pick(i_req, sel_q);
                        gnt_d = 4'(1) << rr_pick(i_req, sel_q);
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        busy_d  = 1'b0;
                    end
                end else if (|others) begin
                    if (cnt_q == HOLD_LIM) begin
                        // Starvation bound reached: rotate away from the owner.
                        last_d = sel_q;
                        cnt_d  = '0;
                        sel_d  = rr_pick(others, sel_q);
                        gnt_d  = 4'(1) << rr_pick(others, sel_q);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (cnt_q != HOLD_LIM) begin
                    // Uncontended: keep counting but saturate at the bound.
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_gnt      = gnt_q;
    assign o_sel      = sel_q;
    assign o_busy     = busy_q;
    assign o_hold_cnt = cnt_q;

endmodule
